// File: rtl/io_stream_write_array_pkg.sv
// Shared widths, FSM encoding and boolean constants for the array-to-stream
// transmit path and its companion receive path.
package io_stream_write_array_pkg;

    localparam int intN  = 8;
    localparam int addrN = 8;

    localparam logic true  = 1'b1;
    localparam logic false = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/io_stream_write_array_fifo.sv
// Two-entry registered FIFO; the head register drives the consumer directly so
// downstream data never depends combinationally on the producer.
module stream_fifo2
    import io_stream_write_array_pkg::*;
#(
    parameter int W = intN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic         head_valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != FIFO_DEPTH) || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = data_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o       = head_q;
    assign head_valid_o = (count_q != 2'd0);
    assign count_o      = count_q;

endmodule

// File: rtl/io_stream_write_array.sv
// Reads words 0..len-1 from an array port and streams them out in order,
// buffering through a 2-entry FIFO so array reads and consumer stalls decouple.
module io_stream_write_array
    import io_stream_write_array_pkg::*;
#(
    parameter int INT_N  = intN,
    parameter int ADDR_N = addrN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [ADDR_N-1:0] len,
    output logic [ADDR_N-1:0] arr_addr,
    output logic              arr_we,
    output logic [INT_N-1:0]  arr_di,
    output logic              arr_valid,
    input  logic              arr_ready,
    input  logic [INT_N-1:0]  arr_do,
    output logic [INT_N-1:0]  sOut,
    output logic              sOut_valid,
    input  logic              sOut_ready
);

    state_t            state_q, state_d;
    logic [ADDR_N-1:0] rd_idx_q, rd_idx_d;
    logic [ADDR_N-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_N-1:0] remaining_q, remaining_d;

    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic [INT_N-1:0]  fifo_head;
    logic              st_fire;
    logic              rd_req;
    logic              rd_fire;

    assign st_fire = fifo_valid && sOut_ready;
    assign rd_req  = (state_q == ST_RUN) && (rd_cnt_q != '0)
                     && ((fifo_count != FIFO_DEPTH) || st_fire);
    assign rd_fire = rd_req && arr_ready;

    stream_fifo2 #(
        .W(INT_N)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_fire),
        .pop_i       (st_fire),
        .data_i      (arr_do),
        .head_o      (fifo_head),
        .head_valid_o(fifo_valid),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        rd_cnt_d    = rd_cnt_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rd_idx_d    = '0;
                    rd_cnt_d    = len;
                    remaining_d = len;
                    state_d     = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_fire) begin
                    rd_idx_d = rd_idx_q + ADDR_N'(1);
                    rd_cnt_d = rd_cnt_q - ADDR_N'(1);
                end
                // Completion tracks delivered words, not issued reads.
                if (st_fire) begin
                    remaining_d = remaining_q - ADDR_N'(1);
                    if (remaining_q == ADDR_N'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_idx_q    <= '0;
            rd_cnt_q    <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            rd_cnt_q    <= rd_cnt_d;
            remaining_q <= remaining_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign arr_addr   = rd_idx_q;
    assign arr_valid  = rd_req;
    assign arr_we     = false;
    assign arr_di     = '0;
    assign sOut       = fifo_head;
    assign sOut_valid = fifo_valid;

endmodule

// File: tb/tb_io_stream_write_array.sv
// Directed bench: a monitor scoreboards every stream word, array read and
// handshake rule while the main thread sequences the start/complete scenarios.
module tb_io_stream_write_array;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] len;
    logic [7:0] arr_addr;
    logic       arr_we;
    logic [7:0] arr_di;
    logic       arr_valid;
    logic       arr_ready;
    logic [7:0] arr_do;
    logic [7:0] sOut;
    logic       sOut_valid;
    logic       sOut_ready;

    logic [7:0] mem [0:255];
    assign arr_do = mem[arr_addr];

    int vectors = 0;
    int fails   = 0;
    int accepts = 0;
    int reads_run = 0;
    int xfers_run = 0;
    int max_occ = 0;
    int s_mode = 0;
    int a_mode = 0;
    int cyc = 0;
    logic [7:0] exp_q [$];

    io_stream_write_array dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .len       (len),
        .arr_addr  (arr_addr),
        .arr_we    (arr_we),
        .arr_di    (arr_di),
        .arr_valid (arr_valid),
        .arr_ready (arr_ready),
        .arr_do    (arr_do),
        .sOut      (sOut),
        .sOut_valid(sOut_valid),
        .sOut_ready(sOut_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ready patterns: s_mode 1 gives sOut_ready 1,0,0,...; a_mode 1 gives arr_ready every 3rd cycle.
    initial begin
        sOut_ready = 1'b1;
        arr_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            sOut_ready = (s_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            arr_ready  = (a_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        end
    end

    // Monitor: samples mid-cycle, so what it sees is what the next posedge commits.
    initial begin
        int   occ;
        logic prev_sv, prev_sr, prev_av, prev_ar;
        logic [7:0] prev_sout, prev_addr;
        int   prev_occ;
        logic push, pop;
        logic [7:0] exp_word;
        occ = 0; prev_sv = 0; prev_sr = 0; prev_av = 0; prev_ar = 0;
        prev_sout = 0; prev_addr = 0; prev_occ = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                occ = 0; prev_sv = 0; prev_av = 0;
                exp_q.delete();
            end else begin
                push = arr_valid && arr_ready;
                pop  = sOut_valid && sOut_ready;
                check("sout_valid_vs_occupancy", int'(sOut_valid), int'(occ != 0));
                if (prev_sv && !prev_sr) begin
                    check("sout_valid_held", int'(sOut_valid), 1);
                    check("sout_data_held", int'(sOut), int'(prev_sout));
                end
                if (prev_av && !prev_ar && prev_occ < 2) begin
                    check("arr_valid_held", int'(arr_valid), 1);
                    check("arr_addr_held", int'(arr_addr), int'(prev_addr));
                end
                if (occ == 2 && !pop) check("arr_valid_low_when_full", int'(arr_valid), 0);
                if (push) begin
                    check("arr_addr_order", int'(arr_addr), reads_run);
                    reads_run++;
                end
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", int'(sOut), -1);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check("sout_data", int'(sOut), int'(exp_word));
                    end
                    xfers_run++;
                end
                occ = occ + int'(push) - int'(pop);
                if (occ > max_occ) max_occ = occ;
                if (push) check("fifo_occupancy_le2", int'(occ <= 2), 1);
                if (in_valid && in_ready) begin
                    accepts++;
                    reads_run = 0;
                    xfers_run = 0;
                    max_occ   = 0;
                    for (int k = 0; k < int'(len); k++) exp_q.push_back(8'(k));
                end
                prev_sv = sOut_valid; prev_sr = sOut_ready; prev_sout = sOut;
                prev_av = arr_valid;  prev_ar = arr_ready;  prev_addr = arr_addr;
                prev_occ = occ;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   int'(in_ready),   1);
        check({tag, "_out_valid"},  int'(out_valid),  0);
        check({tag, "_arr_valid"},  int'(arr_valid),  0);
        check({tag, "_arr_addr"},   int'(arr_addr),   0);
        check({tag, "_sout_valid"}, int'(sOut_valid), 0);
        check({tag, "_sout"},       int'(sOut),       0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Issues a start; exp_n >= 0 checks edges from acceptance to out_valid.
    task automatic start_run(input logic [7:0] l, input int exp_n);
        int n;
        len = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(n);
        if (exp_n >= 0) check($sformatf("latency_len%0d", l), n, exp_n);
        else check($sformatf("done_reached_len%0d", l), int'(out_valid), 1);
    endtask

    task automatic finish_run(input int l);
        check("in_ready_low_in_done", int'(in_ready), 0);
        @(negedge clk);
        check($sformatf("reads_len%0d", l), reads_run, l);
        check($sformatf("words_len%0d", l), xfers_run, l);
        check("scoreboard_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_out_ready", int'(in_ready), 1);
        check("out_valid_after_out_ready", int'(out_valid), 0);
    endtask

    initial begin
        int n;
        int base;
        rst = 1'b1; in_valid = 1'b0; len = 8'd0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full-rate burst of 16 words.
        start_run(8'd16, 17);
        finish_run(16);

        // Zero-length run.
        start_run(8'd0, 0);
        finish_run(0);

        // Consumer backpressure 1,0,0 pattern.
        s_mode = 1;
        start_run(8'd8, -1);
        check("max_occupancy_len8", max_occ, 2);
        finish_run(8);
        s_mode = 0;

        // Array answering every third cycle.
        a_mode = 1;
        start_run(8'd4, -1);
        finish_run(4);
        a_mode = 0;

        // Asynchronous reset after five of ten words.
        len = 8'd10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (xfers_run < 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_5_words", int'(xfers_run >= 5), 1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_run(8'd3, 4);
        finish_run(3);

        // in_valid held high across a run; completion withheld in DONE.
        base = accepts;
        len = 8'd2;
        in_valid = 1'b1;
        wait_done(n);
        check("held_start_done", int'(out_valid), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("out_valid_held_in_done", int'(out_valid), 1);
        end
        check("single_accept_while_held", accepts - base, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("second_accept_after_idle", accepts - base, 2);
        in_valid = 1'b0;
        wait_done(n);
        check("second_run_done", int'(out_valid), 1);
        finish_run(2);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/io_stream_write_array.md
Name: io_stream_write_array

Overview:
- Transmit-side counterpart of io_stream_read_array: on a sync start, reads words 0..len-1 from an Array-interface memory and emits them in order on an output stream.
- Sits between the shared `array` block, acting as Array master with read-only access, and a stream consumer.
- A 2-entry skid FIFO decouples array reads from stream backpressure, sustaining 1 word/cycle when the array and consumer never stall.

Parameters:
- INT_N, 8, data word width (matches `intN`).
- ADDR_N, 8, array address and length width (matches `addrN`).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  start request; len is sampled when in_valid&&in_ready.
- in_ready  out  1  high only in IDLE.
- out_valid  out  1  completion; high in DONE until out_ready.
- out_ready  in  1  completion accept.
- len  in  ADDR_N  number of words to send; 0 is legal.
- arr_addr  out  ADDR_N  read address.
- arr_we  out  1  tied 0.
- arr_di  out  INT_N  tied 0.
- arr_valid  out  1  read request.
- arr_ready  in  1  array completes the request this cycle.
- arr_do  in  INT_N  read data, valid when arr_valid&&arr_ready.
- sOut  out  INT_N  stream data.
- sOut_valid  out  1  stream data valid.
- sOut_ready  in  1  consumer accept.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, rd_idx=0, remaining=0, FIFO empty.
- Outputs in reset: in_ready=1, out_valid=0, arr_valid=0, arr_addr=0, sOut_valid=0, sOut=0.
- Read handshake: a read completes on a cycle with arr_valid&&arr_ready. arr_do is captured into the FIFO in that same cycle. No outstanding reads exist beyond that cycle.
- Stream handshake: a word transfers on sOut_valid&&sOut_ready.
  - sOut and sOut_valid come from the FIFO head register, never combinationally from arr_do.
  - Once sOut_valid is asserted, neither sOut_valid nor sOut changes until the word is accepted.
- IDLE:
  - On in_valid: latch len into rd_cnt and remaining, set rd_idx=0.
  - If len==0, go to DONE; otherwise go to RUN.
- RUN:
  - arr_valid = (rd_cnt!=0) && (fifo_count<2 || sOut_ready&&sOut_valid). Simultaneous push and pop with a full FIFO is legal.
  - arr_addr = rd_idx.
  - On read completion: push arr_do, rd_idx++, rd_cnt--.
  - On each stream transfer: remaining--.
  - When remaining reaches 0 on a transfer, go to DONE the next cycle.
- DONE: out_valid=1. On out_ready, go to IDLE.
- Latency: first read is issued the cycle after start acceptance. First sOut_valid comes 1 cycle after that read completes. Best case is len+2 cycles from start to out_valid.
- Width: rd_idx never exceeds len-1, so no address wrap occurs. len = 2^ADDR_N-1 is the maximum.
- start is ignored outside IDLE (in_ready=0).
- sOut_ready held low: at most 2 words are buffered and arr_valid drops. No data is lost or reordered.
- arr_ready low: arr_valid and arr_addr are held stable until the request completes.
- Reset mid-RUN: FIFO contents are discarded and sOut_valid drops immediately (asynchronous).

Decomposition:
- Shared package/primitives: INT_N/ADDR_N defaults via `intN`/`addrN`, state encoding constants (IDLE/RUN/DONE), `true`/`false`.
- Sub-module stream_fifo2:
  - 2-entry registered FIFO with push/pop/count, async active-high reset.
  - Exposes head data/valid.
  - Reusable by io_stream_read_array for symmetric buffering.

Test Plan:
- Array preloaded 0..15, len=16, sOut_ready=1, arr_ready=1 → sOut emits 0,1,…,15 on consecutive cycles. out_valid is high 1 cycle after word 15. Total ≤18 cycles from start.
- len=0 → no arr_valid and no sOut_valid; out_valid 1 cycle after start; in_ready returns after out_ready.
- len=8 with sOut_ready toggling 1,0,0,1,… → sequence 0..7 exact. sOut is stable while valid&&!ready. fifo_count never exceeds 2. arr_valid is low while the FIFO is full and there is no pop.
- len=4 with arr_ready asserted every 3rd cycle → arr_addr is held through stalls. Output 0..3. No duplicate reads: exactly 4 arr_valid&&arr_ready events.
- Reset asserted mid-RUN after 5 words (len=10) → all outputs return to reset values asynchronously. A new start with len=3 emits 0,1,2 and restarts from addr 0.
- in_valid held high through RUN/DONE with out_ready=0 in DONE → exactly one run. out_valid stays high until out_ready. A second run starts only after return to IDLE.
